// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between execute and writeback.
// Accepts one op at a time from execute, issues a single data-bus request for
// aligned loads/stores, extracts/extends load data, and hands the result to
// writeback. Misaligned accesses raise out_adel/out_ades with no bus request.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake (ready only when idle)
//   in_op, in_addr, in_vt, in_kill op code, effective address, rt value, flush
//   dreq_*                         data-bus request (held stable until addr_ok)
//   dresp_addr_ok/data_ok/data     data-bus acceptance and response
//   out_valid/out_ready            downstream handshake
//   out_data, out_adel, out_ades, out_badvaddr  result and address-error info
//
// Build option: define MEM_UNALIGNED_LR_EN to support LWL/LWR/SWL/SWR; when it
// is undefined those ops pass in_vt through with no bus request.
module mem_access_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_vt,
  input  logic        in_kill,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_adel,
  output logic        out_ades,
  output logic [31:0] out_badvaddr
);

`ifdef MEM_UNALIGNED_LR_EN
  localparam bit LR_EN = 1'b1;
`else
  localparam bit LR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  // Reserved codes 13-15 are listed so any 4-bit input casts cleanly.
  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
    OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_R13, OP_R14, OP_R15
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] vt_q, vt_d;
  logic [31:0] res_q, res_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;
  logic [31:0] badv_q, badv_d;
  logic        killed_q, killed_d;

  op_e  op_in;
  logic is_lr_in, is_store_in, misal_in, passthru_in;

  function automatic logic [31:0] load_result(op_e op, logic [1:0] a,
                                              logic [31:0] vt, logic [31:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = m[{a, 3'b000} +: 8];
    h = a[1] ? m[31:16] : m[15:0];
    r = '0;
    case (op)
      OP_LB:  r = {{24{b[7]}}, b};
      OP_LBU: r = {24'h0, b};
      OP_LH:  r = {{16{h[15]}}, h};
      OP_LHU: r = {16'h0, h};
      OP_LW:  r = m;
      OP_LWL: case (a)
        2'd0:    r = {m[7:0],  vt[23:0]};
        2'd1:    r = {m[15:0], vt[15:0]};
        2'd2:    r = {m[23:0], vt[7:0]};
        default: r = m;
      endcase
      OP_LWR: case (a)
        2'd0:    r = m;
        2'd1:    r = {vt[31:24], m[31:8]};
        2'd2:    r = {vt[31:16], m[31:16]};
        default: r = {vt[31:8],  m[31:24]};
      endcase
      default: r = '0;
    endcase
    return r;
  endfunction

  // Input decode, used only on acceptance in IDLE.
  always_comb begin
    op_in       = op_e'(in_op);
    is_lr_in    = op_in inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
    is_store_in = op_in inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
    case (op_in)
      OP_LH, OP_LHU, OP_SH: misal_in = in_addr[0];
      OP_LW, OP_SW:         misal_in = |in_addr[1:0];
      default:              misal_in = 1'b0;
    endcase
    passthru_in = (op_in inside {OP_NONE, OP_R13, OP_R14, OP_R15}) ||
                  (is_lr_in && !LR_EN);
  end

  // Bus request fields come straight from the registered op so they stay
  // stable for as long as the stage sits in REQ.
  always_comb begin
    dreq_valid  = (state_q == S_REQ);
    dreq_addr   = (op_q inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR}) ?
                  {addr_q[31:2], 2'b00} : addr_q;
    dreq_strobe = '0;
    dreq_data   = '0;
    case (op_q)
      OP_LB, OP_LBU, OP_SB: dreq_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: dreq_size = 2'd1;
      default:              dreq_size = 2'd2;
    endcase
    case (op_q)
      OP_SB: begin
        dreq_strobe = 4'b0001 << addr_q[1:0];
        dreq_data   = {4{vt_q[7:0]}};
      end
      OP_SH: begin
        dreq_strobe = 4'b0011 << addr_q[1:0];
        dreq_data   = {2{vt_q[15:0]}};
      end
      OP_SW: begin
        dreq_strobe = 4'b1111;
        dreq_data   = vt_q;
      end
      OP_SWL: begin
        dreq_strobe = 4'b1111 >> (2'd3 - addr_q[1:0]);
        dreq_data   = vt_q >> {(2'd3 - addr_q[1:0]), 3'b000};
      end
      OP_SWR: begin
        dreq_strobe = 4'b1111 << addr_q[1:0];
        dreq_data   = vt_q << {addr_q[1:0], 3'b000};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    vt_d     = vt_q;
    res_d    = res_q;
    adel_d   = adel_q;
    ades_d   = ades_q;
    badv_d   = badv_q;
    killed_d = killed_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !in_kill) begin
          op_d     = op_in;
          addr_d   = in_addr;
          vt_d     = in_vt;
          res_d    = '0;
          adel_d   = 1'b0;
          ades_d   = 1'b0;
          badv_d   = '0;
          killed_d = 1'b0;
          if (passthru_in) begin
            res_d   = is_lr_in ? in_vt : in_addr;
            state_d = S_DONE;
          end else if (misal_in) begin
            adel_d  = !is_store_in;
            ades_d  = is_store_in;
            badv_d  = in_addr;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A kill here is remembered; the bus transaction still runs to completion.
        killed_d = killed_q | in_kill;
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            res_d   = load_result(op_q, addr_q[1:0], vt_q, dresp_data);
            state_d = killed_d ? S_IDLE : S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        killed_d = killed_q | in_kill;
        if (dresp_data_ok) begin
          res_d   = load_result(op_q, addr_q[1:0], vt_q, dresp_data);
          state_d = killed_d ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (in_kill || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NONE;
      addr_q   <= '0;
      vt_q     <= '0;
      res_q    <= '0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      badv_q   <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      vt_q     <= vt_d;
      res_q    <= res_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
      badv_q   <= badv_d;
      killed_q <= killed_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_data     = res_q;
  assign out_adel     = adel_q;
  assign out_ades     = ades_q;
  assign out_badvaddr = badv_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a result scoreboard.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_vt = '0;
  logic        in_kill = 1'b0;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_adel;
  logic        out_ades;
  logic [31:0] out_badvaddr;

  mem_access_stage dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_vt(in_vt), .in_kill(in_kill),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        adel;
    logic        ades;
    logic [31:0] badv;
    bit          cmp_data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic adel, input logic ades,
                      input logic [31:0] badv, input bit cmp);
    exp_t e;
    e.data = d; e.adel = adel; e.ades = ades; e.badv = badv; e.cmp_data = cmp;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] vt);
    int unsigned n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("issue_ready", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_vt = vt;
    step();
    in_valid = 1'b0; in_op = '0; in_addr = $urandom; in_vt = $urandom;
  endtask

  task automatic req_fields(input string tag, input logic [31:0] ea, input logic [1:0] esz,
                            input logic [3:0] est, input logic [31:0] ed, input bit cd);
    chk({tag, "_valid"}, dreq_valid, 1);
    chk({tag, "_addr"}, dreq_addr, ea);
    chk({tag, "_size"}, dreq_size, esz);
    chk({tag, "_strobe"}, dreq_strobe, est);
    if (cd) chk({tag, "_wdata"}, dreq_data, ed);
  endtask

  task automatic serve(input logic [31:0] ea, input logic [1:0] esz, input logic [3:0] est,
                       input logic [31:0] ed, input bit cd, input int unsigned aw,
                       input int unsigned dw, input logic [31:0] rd);
    req_fields("req", ea, esz, est, ed, cd);
    for (int i = 0; i < aw; i++) begin
      step();
      req_fields("hold", ea, esz, est, ed, cd);
    end
    dresp_addr_ok = 1'b1;
    dresp_data_ok = (dw == 0);
    dresp_data    = rd;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    chk("req_drop", dreq_valid, 0);
    if (dw > 0) begin
      for (int i = 1; i < dw; i++) step();
      dresp_data_ok = 1'b1;
      dresp_data    = rd;
      step();
      dresp_data_ok = 1'b0;
    end
    dresp_data = $urandom;
  endtask

  task automatic collect();
    exp_t e;
    int unsigned n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("out_valid", out_valid, 1);
    if (out_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed=0 expected=nonzero");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.cmp_data) chk("out_data", out_data, e.data);
        chk("out_adel", out_adel, e.adel);
        chk("out_ades", out_ades, e.ades);
        chk("out_badvaddr", out_badvaddr, e.badv);
      end
      out_ready = 1'b1;
      step();
      chk("retire_ready", in_ready, 1);
      chk("retire_valid", out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_adel", out_adel, 0);
    chk("rst_ades", out_ades, 0);
    chk("rst_badv", out_badvaddr, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // NONE passthrough, one-cycle latency; reserved op 13 acts as NONE
    push(32'hDEAD_BEEF, 0, 0, 0, 1);
    issue(4'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    chk("none_latency", out_valid, 1);
    chk("none_noreq", dreq_valid, 0);
    collect();
    push(32'h1313_1313, 0, 0, 0, 1);
    issue(4'd13, 32'h1313_1313, 32'h0);
    chk("op13_noreq", dreq_valid, 0);
    collect();

    // Loads from one bus word 0x80FF_FF00
    push(32'hFFFF_FF80, 0, 0, 0, 1);
    issue(4'd1, 32'h0000_1003, 32'h0);
    serve(32'h0000_1003, 2'd0, 4'b0000, 32'h0, 0, 0, 1, 32'h80FF_FF00);
    chk("lb_latency", out_valid, 1);
    collect();
    push(32'h0000_0080, 0, 0, 0, 1);
    issue(4'd2, 32'h0000_1003, 32'h0);
    serve(32'h0000_1003, 2'd0, 4'b0000, 32'h0, 0, 0, 1, 32'h80FF_FF00);
    collect();
    push(32'hFFFF_80FF, 0, 0, 0, 1);
    issue(4'd3, 32'h0000_1002, 32'h0);
    serve(32'h0000_1002, 2'd1, 4'b0000, 32'h0, 0, 1, 2, 32'h80FF_FF00);
    collect();
    push(32'h0000_FF00, 0, 0, 0, 1);
    issue(4'd4, 32'h0000_1000, 32'h0);
    serve(32'h0000_1000, 2'd1, 4'b0000, 32'h0, 0, 0, 1, 32'h80FF_FF00);
    collect();

    // LW with addr_ok held off 3 cycles, addr_ok+data_ok together
    push(32'h80FF_FF00, 0, 0, 0, 1);
    issue(4'd5, 32'h0000_1000, 32'h0);
    serve(32'h0000_1000, 2'd2, 4'b0000, 32'h0, 0, 3, 0, 32'h80FF_FF00);
    chk("lw_same_cycle", out_valid, 1);
    collect();

    // Stores return zero regardless of bus data
    push(32'h0, 0, 0, 0, 1);
    issue(4'd9, 32'h0000_2002, 32'h1234_ABCD);
    serve(32'h0000_2002, 2'd1, 4'b1100, 32'hABCD_ABCD, 1, 1, 1, 32'h5A5A_5A5A);
    collect();
    push(32'h0, 0, 0, 0, 1);
    issue(4'd8, 32'h0000_2001, 32'hFFFF_FFA5);
    serve(32'h0000_2001, 2'd0, 4'b0010, 32'hA5A5_A5A5, 1, 0, 1, 32'h5A5A_5A5A);
    collect();
    push(32'h0, 0, 0, 0, 1);
    issue(4'd10, 32'h0000_2000, 32'hCAFE_F00D);
    serve(32'h0000_2000, 2'd2, 4'b1111, 32'hCAFE_F00D, 1, 2, 2, 32'h5A5A_5A5A);
    collect();

    // Misaligned accesses: flags, badvaddr, no bus request
    push(32'h0, 1, 0, 32'h0000_2001, 0);
    issue(4'd5, 32'h0000_2001, 32'h0);
    chk("lw_mis_noreq", dreq_valid, 0);
    collect();
    push(32'h0, 0, 1, 32'h0000_2002, 0);
    issue(4'd10, 32'h0000_2002, 32'h1111_2222);
    chk("sw_mis_noreq", dreq_valid, 0);
    collect();
    push(32'h0, 1, 0, 32'h0000_3001, 0);
    issue(4'd4, 32'h0000_3001, 32'h0);
    collect();
    push(32'h0, 0, 1, 32'h0000_3003, 0);
    issue(4'd9, 32'h0000_3003, 32'h0);
    collect();

`ifdef MEM_UNALIGNED_LR_EN
    push(32'h2211_CCDD, 0, 0, 0, 1);
    issue(4'd6, 32'h0000_0011, 32'hAABB_CCDD);
    serve(32'h0000_0010, 2'd2, 4'b0000, 32'h0, 0, 0, 1, 32'h4433_2211);
    collect();
    push(32'h0, 0, 0, 0, 1);
    issue(4'd12, 32'h0000_0012, 32'hAABB_CCDD);
    serve(32'h0000_0010, 2'd2, 4'b1100, 32'hCCDD_0000, 1, 0, 1, 32'h0);
    collect();
`else
    push(32'hAABB_CCDD, 0, 0, 0, 1);
    issue(4'd6, 32'h0000_0011, 32'hAABB_CCDD);
    chk("lwl_noreq", dreq_valid, 0);
    collect();
    push(32'h0BAD_F00D, 0, 0, 0, 1);
    issue(4'd12, 32'h0000_0012, 32'h0BAD_F00D);
    chk("swr_noreq", dreq_valid, 0);
    collect();
`endif

    // Kill while waiting for data: bus completes, no out_valid
    issue(4'd5, 32'h0000_4000, 32'h0);
    chk("kw_req", dreq_valid, 1);
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    in_kill = 1'b1;
    step();
    in_kill = 1'b0;
    chk("kw_wait_noout", out_valid, 0);
    dresp_data = 32'h1234_5678;
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    chk("kw_no_valid", out_valid, 0);
    chk("kw_idle", in_ready, 1);
    step();
    chk("kw_no_valid2", out_valid, 0);

    // Kill in DONE drops the result
    out_ready = 1'b0;
    issue(4'd0, 32'h0000_0077, 32'h0);
    chk("kd_done", out_valid, 1);
    in_kill = 1'b1;
    step();
    in_kill = 1'b0;
    chk("kd_idle", in_ready, 1);
    chk("kd_no_valid", out_valid, 0);
    out_ready = 1'b1;

    // Asynchronous reset while requesting
    issue(4'd5, 32'h0000_5000, 32'h0);
    chk("ar_req", dreq_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_dreq_low", dreq_valid, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("ar_in_ready", in_ready, 1);

    // Backpressure in DONE: outputs hold, no acceptance
    out_ready = 1'b0;
    push(32'h5555_AAAA, 0, 0, 0, 1);
    issue(4'd0, 32'h5555_AAAA, 32'h0);
    in_valid = 1'b1;
    in_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'h5555_AAAA);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    collect();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 in_valid/in_ready  in/out  1/1  upstream handshake from the execute stage.
REQ-005 in_op  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; values 13-15 SHALL be treated as NONE.
REQ-006 in_addr  in  32  ALU result: the effective address, or the passthrough value when in_op is NONE.
REQ-007 in_vt  in  32  rt value: store data, and the merge source for LWL/LWR.
REQ-008 in_kill  in  1  pipeline flush.
REQ-009 dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data  out  1, 32, 2, 4, 32  data-bus request; size 0 = byte, 1 = half, 2 = word; strobe is 0 for loads.
REQ-010 dresp_addr_ok, dresp_data_ok, dresp_data  in  1, 1, 32  data-bus request acceptance and response.
REQ-011 out_valid/out_ready  out/in  1/1  downstream handshake to writeback.
REQ-012 out_data  out  32  result word.
REQ-013 out_adel, out_ades  out  1, 1  load and store address-error flags.
REQ-014 out_badvaddr  out  32  faulting address.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: when in_valid and not in_kill, the stage SHALL register op, addr and vt.
  - Next state is REQ for a legal memory op.
  - Next state is DONE for NONE or a misaligned op.
REQ-018 Misalignment rules:
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] != 0.
  - Misaligned loads SHALL set out_adel; misaligned stores SHALL set out_ades.
  - out_badvaddr = addr; no bus request is issued.
REQ-019 REQ: dreq_valid = 1, with all dreq_* held stable until dresp_addr_ok.
  - addr_ok alone -> WAIT.
  - addr_ok and data_ok in the same cycle -> DONE.
REQ-020 WAIT: dresp_data_ok -> DONE; the load result SHALL be captured in that cycle.
REQ-021 DONE with out_ready -> IDLE; no new input is accepted in the same cycle.
REQ-022 Latency:
  - NONE accepted in cycle N -> out_valid in N+1, with out_data = in_addr.
  - Memory op accepted in N, addr_ok in N+1, data_ok in N+2 -> out_valid in N+3.
REQ-023 Address and size:
  - dreq_addr = addr for B/H/W ops.
  - dreq_addr = {addr[31:2], 2'b00} for LWL/LWR/SWL/SWR.
  - dreq_size = 0 for B, 1 for H, 2 for W/LWL/LWR/SWL/SWR.
REQ-024 Store strobe and data, with a = addr[1:0]:
  - SB: strobe 0001 << a, data {4{vt[7:0]}}.
  - SH: strobe 0011 << a, data {2{vt[15:0]}}.
  - SW: strobe 1111, data vt.
REQ-025 Load extraction, little-endian:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: full word.
  - Stores SHALL return out_data = 0.
REQ-026 Kill in REQ or WAIT:
  - The transaction SHALL still complete on the bus and is never withdrawn.
  - The stage SHALL then return to IDLE without asserting out_valid.
REQ-027 Kill in DONE SHALL return the stage to IDLE next cycle.

Reset
REQ-028 resetn = 0 SHALL immediately force IDLE, including mid-transaction, and drive these outputs low: dreq_valid, out_valid, out_adel, out_ades, out_data, out_badvaddr and the kill-drop flag.
REQ-029 in_ready SHALL be 1 one cycle after resetn deasserts.

Configuration
REQ-030 Macro MEM_UNALIGNED_LR_EN defined: LWL/LWR/SWL/SWR SHALL be fully supported. With m = bus word and a = addr[1:0]:
  - LWL a = 0..3: {m[7:0], vt[23:0]}, {m[15:0], vt[15:0]}, {m[23:0], vt[7:0]}, m.
  - LWR a = 0..3: m, {vt[31:24], m[31:8]}, {vt[31:16], m[31:16]}, {vt[31:8], m[31:24]}.
  - SWL: strobe 0001/0011/0111/1111, data vt >> 8*(3 - a).
  - SWR: strobe 1111/1110/1100/1000, data vt << 8*a.
REQ-031 Macro MEM_UNALIGNED_LR_EN undefined: the four ops SHALL behave as NONE, with no bus request and out_data = in_vt.

Verification
REQ-032 LB, addr 0x1003, dresp_data 0x80FF_FF00 -> dreq_size 0; out_data 0xFFFF_FF80.
REQ-033 SH, addr 0x2002, vt 0x1234_ABCD -> dreq_strobe 1100, dreq_data 0xABCD_ABCD; LW at 0x2001 -> out_adel = 1, out_badvaddr 0x2001, dreq_valid never rises.
REQ-034 LW with addr_ok held off 3 cycles -> dreq_* held stable; addr_ok and data_ok in the same cycle -> out_valid the next cycle.
REQ-035 MEM_UNALIGNED_LR_EN defined: LWL, addr 0x11, vt 0xAABB_CCDD, m 0x4433_2211 -> out_data 0x2211_CCDD; SWR, addr 0x12 -> strobe 1100, data vt << 16.
REQ-036 in_kill in WAIT -> no out_valid after data_ok; resetn pulse in REQ -> dreq_valid drops asynchronously.
REQ-037 out_ready held low 5 cycles in DONE -> out_valid and out_data held stable, in_ready = 0.
